// File: rtl/quan_weight_feed_if.sv
// Command, weight-buffer read and skew-chain feed signals of quan_weight_feed_ctrl.
// slave is the controller side; master is the surrounding environment (command source and buffer).
interface quan_weight_feed_if #(
    parameter int ROWS   = 16,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
);
    logic                start;
    logic [ADDR_W-1:0]   base_addr;
    logic [LEN_W-1:0]    vec_num;
    logic                pause;
    logic                buf_rd_en;
    logic [ADDR_W-1:0]   buf_rd_addr;
    logic [ROWS*8-1:0]   buf_rd_data;
    logic [ROWS*8-1:0]   weights_out;
    logic [ROWS-1:0]     row_valid;
    logic                busy;
    logic                done;

    modport slave (
        input  start, base_addr, vec_num, pause, buf_rd_data,
        output buf_rd_en, buf_rd_addr, weights_out, row_valid, busy, done
    );

    modport master (
        output start, base_addr, vec_num, pause, buf_rd_data,
        input  buf_rd_en, buf_rd_addr, weights_out, row_valid, busy, done
    );
endinterface

// File: rtl/quan_weight_feed_ctrl.sv
// Streams vec_num weight-buffer words into the systolic array's weight skew chain with a skewed row-valid mask.
// Optional QUAN_WFEED_ZERO_GATE_EN: zero weights_out on cycles that carry no freshly read word.
module quan_weight_feed_ctrl #(
    parameter int row_num_in_sa    = 16,
    parameter int column_num_in_sa = 16,
    parameter int ADDR_W           = 10,
    parameter int LEN_W            = 10
) (
    input  logic                clk,
    input  logic                rst,
    quan_weight_feed_if.slave   bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FEED  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int FLUSH_W = (row_num_in_sa > 1) ? $clog2(row_num_in_sa) : 1;
    localparam int SR_W    = (row_num_in_sa > 1) ? row_num_in_sa - 1 : 1;
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(row_num_in_sa - 1);

    // Column count only shapes the array itself; nothing here depends on it.
    if (column_num_in_sa < 1) begin : g_no_columns
    end

    logic [1:0]          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    remain_q, remain_d;
    logic [FLUSH_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                issue_v_q, issue_v_d;
    logic [SR_W-1:0]     valid_sr_q, valid_sr_d;

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        addr_d      = addr_q;
        remain_d    = remain_q;
        flush_cnt_d = flush_cnt_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        issue_v_d   = rd_en_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    busy_d = 1'b1;
                    if (bus.vec_num == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = ST_FEED;
                        rd_en_d   = 1'b1;
                        rd_addr_d = bus.base_addr;
                        addr_d    = bus.base_addr + ADDR_W'(1);
                        remain_d  = bus.vec_num - LEN_W'(1);
                    end
                end
            end
            ST_FEED: begin
                // remain_q reaches zero only in the cycle that issues the last read.
                if (remain_q == '0) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = '0;
                end else if (!bus.pause) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = addr_q;
                    addr_d    = addr_q + ADDR_W'(1);
                    remain_d  = remain_q - LEN_W'(1);
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Valid mask follows the skew chain: bit r of row_valid is issue_v delayed r cycles.
    if (row_num_in_sa > 2) begin : g_sr_multi
        assign valid_sr_d = {valid_sr_q[SR_W-2:0], issue_v_q};
    end else begin : g_sr_single
        assign valid_sr_d = issue_v_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remain_q    <= '0;
            flush_cnt_q <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            issue_v_q   <= 1'b0;
            valid_sr_q  <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q     <= state_d;
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            flush_cnt_q <= flush_cnt_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            issue_v_q   <= issue_v_d;
            valid_sr_q  <= valid_sr_d;
        end
    end

    assign bus.buf_rd_en   = rd_en_q;
    assign bus.buf_rd_addr = rd_addr_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

    if (row_num_in_sa > 1) begin : g_rv_multi
        assign bus.row_valid = {valid_sr_q, issue_v_q};
    end else begin : g_rv_single
        assign bus.row_valid = issue_v_q;
    end

`ifdef QUAN_WFEED_ZERO_GATE_EN
    assign bus.weights_out = issue_v_q ? bus.buf_rd_data : '0;
`else
    assign bus.weights_out = bus.buf_rd_data;
`endif

endmodule

// File: tb/tb_quan_weight_feed_ctrl.sv
// Directed bench for quan_weight_feed_ctrl: table of feed jobs checked cycle by cycle, plus a mid-job reset.
// pause is sampled on the clock edge, so the bubble lands in the cycle after the one pause is driven in.
`timescale 1ns/1ps
module tb_quan_weight_feed_ctrl;
    localparam int ROWS       = 16;
    localparam int ADDR_W     = 10;
    localparam int LEN_W      = 10;
    localparam int DW         = ROWS * 8;
    localparam int RUN_CYCLES = 24;

    typedef struct {
        string              name;
        logic [ADDR_W-1:0]  base;
        logic [LEN_W-1:0]   num;
        int                 pause_at;       // bubble cycle, 0 = none
        int                 spur_a;         // cycles with an ignored start, 0 = none
        int                 spur_b;
        int                 exp_reads;
        logic [ADDR_W-1:0]  exp_last_addr;
        int                 exp_done;
    } job_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    quan_weight_feed_if #(.ROWS(ROWS), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    quan_weight_feed_ctrl #(
        .row_num_in_sa(ROWS), .column_num_in_sa(16), .ADDR_W(ADDR_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [DW-1:0] word_of(input logic [ADDR_W-1:0] a);
        logic [DW-1:0] w;
        for (int r = 0; r < ROWS; r++) w[r*8 +: 8] = 8'(int'(a) * 3 + r * 37 + 1);
        return w;
    endfunction

    // Weight buffer: one-cycle read latency.
    always @(posedge clk or posedge rst) begin
        if (rst) bus.buf_rd_data <= '0;
        else if (bus.buf_rd_en) bus.buf_rd_data <= word_of(bus.buf_rd_addr);
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Cycle 0 carries start; cycle k is the k-th clock period after it.
    task automatic run_job(input job_t j);
        logic              exp_rd [0:RUN_CYCLES];
        logic [ADDR_W-1:0] exp_ad [0:RUN_CYCLES];
        logic [ROWS-1:0]   exp_rv;
        logic [ADDR_W-1:0] last_addr;
        int issued;
        int seen_reads;
        int seen_done;
        issued = 0; seen_reads = 0; seen_done = 0; last_addr = '0;

        @(posedge clk); #1;
        bus.start = 1'b1; bus.base_addr = j.base; bus.vec_num = j.num; bus.pause = 1'b0;
        exp_rd[0] = 1'b0; exp_ad[0] = '0;

        for (int cyc = 1; cyc <= RUN_CYCLES; cyc++) begin
            @(posedge clk); #1;
            bus.start = (cyc == j.spur_a) || (cyc == j.spur_b);
            bus.pause = (cyc + 1 == j.pause_at);
            exp_rd[cyc] = (issued < int'(j.num)) && (cyc != j.pause_at);
            exp_ad[cyc] = j.base + ADDR_W'(issued);
            if (exp_rd[cyc]) issued++;
            for (int r = 0; r < ROWS; r++) begin
                exp_rv[r] = 1'b0;
                if (cyc - 1 - r >= 0) exp_rv[r] = exp_rd[cyc-1-r];
            end

            @(negedge clk);
            check($sformatf("%s rd_en@%0d", j.name, cyc), DW'(bus.buf_rd_en), DW'(exp_rd[cyc]));
            if (exp_rd[cyc])
                check($sformatf("%s rd_addr@%0d", j.name, cyc), DW'(bus.buf_rd_addr), DW'(exp_ad[cyc]));
            check($sformatf("%s row_valid@%0d", j.name, cyc), DW'(bus.row_valid), DW'(exp_rv));
            if (exp_rd[cyc-1])
                check($sformatf("%s weights@%0d", j.name, cyc), bus.weights_out, word_of(exp_ad[cyc-1]));
`ifdef QUAN_WFEED_ZERO_GATE_EN
            else
                check($sformatf("%s weights_zero@%0d", j.name, cyc), bus.weights_out, '0);
`endif
            check($sformatf("%s done@%0d", j.name, cyc), DW'(bus.done), DW'(cyc == j.exp_done));
            check($sformatf("%s busy@%0d", j.name, cyc), DW'(bus.busy), DW'(cyc <= j.exp_done));
            if (bus.buf_rd_en === 1'b1) begin
                seen_reads++;
                last_addr = bus.buf_rd_addr;
            end
            if (bus.done === 1'b1) seen_done++;
        end

        check($sformatf("%s read_count", j.name), DW'(seen_reads), DW'(j.exp_reads));
        check($sformatf("%s done_count", j.name), DW'(seen_done), DW'(1));
        if (j.exp_reads > 0)
            check($sformatf("%s last_addr", j.name), DW'(last_addr), DW'(j.exp_last_addr));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " rd_en"},     DW'(bus.buf_rd_en),   '0);
        check({tag, " rd_addr"},   DW'(bus.buf_rd_addr), '0);
        check({tag, " row_valid"}, DW'(bus.row_valid),   '0);
        check({tag, " busy"},      DW'(bus.busy),        '0);
        check({tag, " done"},      DW'(bus.done),        '0);
        check({tag, " weights"},   bus.weights_out,      '0);
    endtask

    job_t jobs [5];
    job_t after_rst;

    initial begin
        jobs[0] = '{"basic4",   10'h010, 10'd4, 0, 0,  0, 4, 10'h013, 21};
        jobs[1] = '{"pause3",   10'h010, 10'd3, 2, 0,  0, 3, 10'h012, 21};
        jobs[2] = '{"zero",     10'h000, 10'd0, 0, 0,  0, 0, 10'h000, 1};
        jobs[3] = '{"wrap4",    10'h3fe, 10'd4, 0, 0,  0, 4, 10'h001, 21};
        jobs[4] = '{"spur4",    10'h020, 10'd4, 0, 3, 10, 4, 10'h023, 21};
        after_rst = '{"post_rst", 10'h100, 10'd2, 0, 0, 0, 2, 10'h101, 19};

        bus.start = 1'b0; bus.base_addr = '0; bus.vec_num = '0; bus.pause = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 5; i++) run_job(jobs[i]);

        // Reset lands in cycle 3 of a 4-vector job, while a read is in flight.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.base_addr = 10'h040; bus.vec_num = 10'd4;
        @(posedge clk); #1 bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_rst pre rd_en",   DW'(bus.buf_rd_en),   DW'(1));
        check("mid_rst pre rd_addr", DW'(bus.buf_rd_addr), DW'(10'h042));
        rst = 1'b1;
        #1 check_all_zero("mid_rst");
        @(negedge clk);
        check_all_zero("mid_rst held");
        @(posedge clk); #1 rst = 1'b0;
        run_job(after_rst);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
